// File: rtl/vgg_stream_pkg.sv
// Shared stream definitions for the VGG pipeline: lane count and FIFO pointer sizing.
package vgg_stream_pkg;

  localparam int NUM_LANES = 8;

  // One extra bit beyond the address so full and empty pointers stay distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/channel_fifo_ram.sv
// Simple dual-port storage for channel_fifo: one write port, registered read port.
module channel_fifo_ram #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Output register holds its word until the next accepted read.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/channel_fifo.sv
// Eight-lane channel FIFO between the stream generator and the line buffer.
// Optional sticky overflow/underflow flags are built when CHANNEL_FIFO_ERR_FLAGS_EN is defined.
module channel_fifo
  import vgg_stream_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wrreq,
  input  logic [NUM_LANES*DWIDTH-1:0]   wr_data,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rdreq,
  output logic [NUM_LANES*DWIDTH-1:0]   rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic [ptr_width(DEPTH)-1:0]   usedw
`ifdef CHANNEL_FIFO_ERR_FLAGS_EN
  ,
  input  logic                          err_clr,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam int WW = NUM_LANES * DWIDTH;
  localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_TH);

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic [PW-1:0] usedw_d, usedw_q;
  logic          rd_valid_d, rd_valid_q;
  logic          wr_acc, rd_acc;

  // Flags come only from the registered count, never from this cycle's requests.
  assign full        = (usedw_q == DEPTH_LVL);
  assign empty       = (usedw_q == '0);
  assign almost_full = (usedw_q >= AFULL_LVL);

  assign wr_acc = wrreq & ~full;
  assign rd_acc = rdreq & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    usedw_d    = usedw_q;
    rd_valid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + PW'(1);
      2'b01:   usedw_d = usedw_q - PW'(1);
      default: usedw_d = usedw_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usedw_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      usedw_q    <= usedw_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  channel_fifo_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (wr_acc),
    .waddr  (wr_ptr_q[AW-1:0]),
    .wdata  (wr_data),
    .re     (rd_acc),
    .raddr  (rd_ptr_q[AW-1:0]),
    .rdata  (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign usedw    = usedw_q;

`ifdef CHANNEL_FIFO_ERR_FLAGS_EN
  logic overflow_d, overflow_q;
  logic underflow_d, underflow_q;

  // Clearing wins over a same-cycle error so software never misses a clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wrreq && full)  overflow_d  = 1'b1;
      if (rdreq && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Self-checking bench for channel_fifo: vector table, reset, error flags and an upstream-coupled frame stream.
module tb_channel_fifo;

  localparam int DW     = 32;
  localparam int D      = 16;
  localparam int WW     = 8 * DW;
  localparam int PW     = 5;
  localparam int FRAME  = 56 * 56;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wrreq, rdreq;
  logic [WW-1:0] wr_data, rd_data;
  logic          full, almost_full, rd_valid, empty;
  logic [PW-1:0] usedw;
`ifdef CHANNEL_FIFO_ERR_FLAGS_EN
  logic          err_clr, overflow, underflow;
`endif

  always #5 clk = ~clk;

  channel_fifo #(.DWIDTH(DW), .DEPTH(D)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .wrreq       (wrreq),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rdreq       (rdreq),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .usedw       (usedw)
`ifdef CHANNEL_FIFO_ERR_FLAGS_EN
    ,
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  typedef struct {
    logic wr;
    logic rd;
    int   n;
    logic acc_wr;
    int   usedw;
    logic full;
    logic empty;
    logic af;
    logic rv;
  } vec_t;

  vec_t          vecs[$];
  logic [WW-1:0] sb[$];
  logic [WW-1:0] last_rd;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [WW-1:0] mk_word(input int n);
    logic [WW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*DW +: DW] = 32'(256 * k + n);
    return w;
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic wr, input logic rd, input int n, input logic acc,
                     input int u, input logic f, input logic e, input logic af, input logic rv);
    vec_t v;
    v.wr = wr; v.rd = rd; v.n = n; v.acc_wr = acc; v.usedw = u;
    v.full = f; v.empty = e; v.af = af; v.rv = rv;
    vecs.push_back(v);
  endtask

  task automatic check_pop(input string name);
    logic [WW-1:0] exp;
    if (sb.size() == 0) begin
      chk({name, "_unexpected_valid"}, WW'(rd_valid), WW'(0));
    end else begin
      exp = sb.pop_front();
      chk(name, rd_data, exp);
      last_rd = exp;
    end
  endtask

  initial begin
    int   sent, recv, cyc, max_used;
    logic af_d0, af_d1;

    // fill, dropped 17th write, drain, ignored read, empty collision, refill, full collision, hold
    for (int n = 0; n < 16; n++) add(1, 0, n, 1, n + 1, n == 15, 0, (n + 1) >= 14, 0);
    add(1, 0, 16, 0, 16, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 15 - i, 0, i == 15, (15 - i) >= 14, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 100, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) add(1, 0, 101 + i, 1, 2 + i, i == 14, 0, (2 + i) >= 14, 0);
    add(1, 1, 200, 0, 15, 0, 0, 1, 1);
    add(0, 0, 0, 0, 15, 0, 0, 1, 0);

    resetn = 1'b0; wrreq = 1'b0; rdreq = 1'b0; wr_data = '0; last_rd = '0;
`ifdef CHANNEL_FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    chk("rst_usedw", WW'(usedw), WW'(0));
    chk("rst_empty", WW'(empty), WW'(1));
    chk("rst_full", WW'(full), WW'(0));
    chk("rst_afull", WW'(almost_full), WW'(0));
    chk("rst_rd_valid", WW'(rd_valid), WW'(0));
    chk("rst_rd_data", rd_data, WW'(0));

    foreach (vecs[i]) begin
      wrreq = vecs[i].wr; rdreq = vecs[i].rd; wr_data = mk_word(vecs[i].n);
      if (vecs[i].acc_wr) sb.push_back(mk_word(vecs[i].n));
      tick();
      chk($sformatf("v%0d_usedw", i), WW'(usedw), WW'(vecs[i].usedw));
      chk($sformatf("v%0d_full", i), WW'(full), WW'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), WW'(empty), WW'(vecs[i].empty));
      chk($sformatf("v%0d_afull", i), WW'(almost_full), WW'(vecs[i].af));
      chk($sformatf("v%0d_rd_valid", i), WW'(rd_valid), WW'(vecs[i].rv));
      if (rd_valid) check_pop($sformatf("v%0d_rd_data", i));
      else chk($sformatf("v%0d_rd_hold", i), rd_data, last_rd);
    end

    // bring occupancy to 9 with the last action a read, then reset mid-stream
    wrreq = 1'b0; rdreq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_valid) check_pop("pre_rst_rd_data");
    end
    rdreq = 1'b0;
    chk("pre_rst_usedw", WW'(usedw), WW'(9));
    chk("pre_rst_rd_valid", WW'(rd_valid), WW'(1));
    resetn = 1'b0;
    #1;
    chk("mid_rst_empty", WW'(empty), WW'(1));
    chk("mid_rst_usedw", WW'(usedw), WW'(0));
    chk("mid_rst_rd_valid", WW'(rd_valid), WW'(0));
    chk("mid_rst_rd_data", rd_data, WW'(0));
    sb.delete();
    tick();
    resetn = 1'b1;
    wrreq = 1'b1; wr_data = mk_word(8'h55); sb.push_back(mk_word(8'h55));
    tick();
    wrreq = 1'b0; rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    chk("post_rst_rd_valid", WW'(rd_valid), WW'(1));
    if (rd_valid) check_pop("post_rst_rd_data");
    chk("post_rst_empty", WW'(empty), WW'(1));

`ifdef CHANNEL_FIFO_ERR_FLAGS_EN
    wrreq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = mk_word(i);
      tick();
    end
    tick();
    wrreq = 1'b0;
    chk("ovf_set", WW'(overflow), WW'(1));
    chk("ovf_udf_clear", WW'(underflow), WW'(0));
    tick();
    chk("ovf_held", WW'(overflow), WW'(1));
    rdreq = 1'b1;
    repeat (16) tick();
    chk("udf_quiet_before_empty_read", WW'(underflow), WW'(0));
    tick();
    chk("udf_set", WW'(underflow), WW'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; rdreq = 1'b0;
    chk("clr_ovf", WW'(overflow), WW'(0));
    chk("clr_udf_priority", WW'(underflow), WW'(0));
    sb.delete();
`endif

    // frame stream: writer gated by almost_full through one register, reader stalls every 3rd cycle
    sent = 0; recv = 0; cyc = 0; max_used = 0; af_d0 = 1'b0; af_d1 = 1'b0;
    while (recv < FRAME && cyc < 20000) begin
      wrreq = !af_d1 && (sent < FRAME);
      wr_data = mk_word(sent);
      if (wrreq) begin
        sb.push_back(mk_word(sent));
        sent++;
      end
      rdreq = (cyc % 3) != 2;
      tick();
      cyc++;
      af_d1 = af_d0;
      af_d0 = almost_full;
      if (int'(usedw) > max_used) max_used = int'(usedw);
      if (rd_valid) begin
        check_pop($sformatf("stream_word%0d", recv));
        recv++;
      end
    end
    wrreq = 1'b0; rdreq = 1'b0;
    chk("stream_words_received", WW'(recv), WW'(FRAME));
    chk("stream_sb_drained", WW'(sb.size()), WW'(0));
    chk("stream_max_usedw_le_16", WW'(max_used <= 16), WW'(1));
    tick();
    chk("stream_end_empty", WW'(empty), WW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_fifo.md
CHANNEL_FIFO -- requirements
Module: channel_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning bits per channel lane.
REQ-002 SHALL have parameter DEPTH, default 16, meaning entries per lane; power of two, 4..1024.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, meaning the usedw level at which almost_full asserts.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port wrreq, input, 1 bit: write request.
REQ-007 SHALL have port wr_data, input, 8*DWIDTH bits: lanes 0..7; lane k occupies [k*DWIDTH +: DWIDTH].
REQ-008 SHALL have port full, output, 1 bit: usedw==DEPTH.
REQ-009 SHALL have port almost_full, output, 1 bit: usedw>=AFULL_TH; the port driven into the generator's fifo_full input.
REQ-010 SHALL have port rdreq, input, 1 bit: read request from the line-buffer stage.
REQ-011 SHALL have port rd_data, output, 8*DWIDTH bits: registered read word, same lane packing.
REQ-012 SHALL have port rd_valid, output, 1 bit: rd_data holds a newly popped word this cycle.
REQ-013 SHALL have port empty, output, 1 bit: usedw==0.
REQ-014 SHALL have port usedw, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 SHALL accept a write when wrreq=1 and full=0 at the clock edge; wrreq while full SHALL be dropped with no state change.
REQ-016 SHALL accept a read when rdreq=1 and empty=0; rdreq while empty SHALL be ignored.
REQ-017 SHALL present the popped word on rd_data with rd_valid=1 exactly one cycle after the accepted read; rd_data SHALL hold its value otherwise.
REQ-018 SHALL store all 8 lanes atomically per write; lanes SHALL never skew.
REQ-019 SHALL use wr_ptr/rd_ptr of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; the RAM address is the low log2(DEPTH) bits.
REQ-020 SHALL update usedw as +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-021 SHALL, when full with wrreq and rdreq both set, accept the read only; usedw becomes DEPTH-1.
REQ-022 SHALL, when empty with wrreq and rdreq both set, accept the write only (no fall-through); usedw becomes 1, rd_valid stays 0.
REQ-023 SHALL derive full, empty and almost_full combinationally from registered usedw only.
REQ-024 SHALL tolerate the upstream one-cycle flag latency: with almost_full driving upstream, at least DEPTH-AFULL_TH further writes after assertion SHALL still be accepted.

Reset
REQ-025 SHALL on resetn=0 clear wr_ptr, rd_ptr, usedw, rd_valid and rd_data to 0, giving empty=1, full=0, almost_full=0.
REQ-026 SHALL discard all stored data on reset mid-operation; RAM contents need not be cleared.

Configuration
REQ-027 SHALL, when macro CHANNEL_FIFO_ERR_FLAGS_EN is defined, add input err_clr and outputs overflow and underflow (1 bit each).
REQ-028 SHALL, with CHANNEL_FIFO_ERR_FLAGS_EN, set overflow on a dropped write (REQ-015) and underflow on an ignored read (REQ-016).
REQ-029 SHALL, with CHANNEL_FIFO_ERR_FLAGS_EN, keep overflow and underflow sticky until err_clr=1 or reset; err_clr SHALL take priority over a same-cycle set.
REQ-030 SHALL, without CHANNEL_FIFO_ERR_FLAGS_EN, omit those ports and logic entirely; behaviour is otherwise identical.

Structure
REQ-031 SHALL take NUM_LANES=8 and a clog2-based pointer-width function from shared package vgg_stream_pkg.
REQ-032 SHALL instantiate one sub-module channel_fifo_ram: simple dual-port, one write port, registered read port, width 8*DWIDTH, depth DEPTH.

Verification
REQ-033 SHALL verify fill: 16 writes with lane k = 0x100*k+n, no reads -> full=1 and usedw=16 after the 16th write; a 17th write is dropped.
REQ-034 SHALL verify drain: from full, 16 back-to-back reads -> rd_data returns n=0..15 in order with rd_valid one cycle after each rdreq; empty=1 at the end.
REQ-035 SHALL verify boundary collisions: read+write while full -> usedw=15; read+write while empty -> usedw=1 and rd_valid=0.
REQ-036 SHALL verify upstream coupling: the generator, driven by almost_full (AFULL_TH=14), streams a 56x56 frame against a reader stalled every 3rd cycle -> no word is lost or duplicated and usedw never exceeds 16.
REQ-037 SHALL verify reset mid-stream: resetn low at usedw=9 -> empty=1, usedw=0 and rd_valid=0 immediately; the next write and read return that new word.
REQ-038 SHALL verify error flags (CHANNEL_FIFO_ERR_FLAGS_EN): write while full -> overflow=1 and held; read while empty -> underflow=1; err_clr pulse -> both 0.
